// File: rtl/hangman_guess_checker_if.sv
// Guess/result bundle between the maze letter logic (master) and the
// hangman guess checker (slave).
interface hangman_guess_checker_if #(
    parameter int WORD_LEN = 8
);
    logic                  init;
    logic [8*WORD_LEN-1:0] secret_word;
    logic [3:0]            word_len;
    logic                  check_guess;
    logic [7:0]            guess_letter;
    logic [WORD_LEN-1:0]   revealed;
    logic [2:0]            wrong_count;
    logic [25:0]           guessed_set;
    logic                  busy;
    logic                  result_valid;
    logic                  hit;
    logic                  repeat_guess;
    logic                  win;
    logic                  lose;

    modport master (
        output init, secret_word, word_len, check_guess, guess_letter,
        input  revealed, wrong_count, guessed_set, busy, result_valid,
               hit, repeat_guess, win, lose
    );

    modport slave (
        input  init, secret_word, word_len, check_guess, guess_letter,
        output revealed, wrong_count, guessed_set, busy, result_valid,
               hit, repeat_guess, win, lose
    );
endinterface

// File: rtl/hangman_guess_checker.sv
// Hangman guess checker: scores each collected letter against the secret
// word one character per clock and tracks revealed positions, misses,
// guessed alphabet and win/lose status.
module hangman_guess_checker #(
    parameter int WORD_LEN  = 8,
    parameter int MAX_WRONG = 6
) (
    input logic               Clk,
    input logic               Reset,
    hangman_guess_checker_if.slave gif
);
    localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, UPDATE, OVER} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          g_q, g_d;
    logic [WORD_LEN-1:0] hit_mask_q, hit_mask_d;
    logic [WORD_LEN-1:0] revealed_q, revealed_d;
    logic [2:0]          wrong_q, wrong_d;
    logic [25:0]         guessed_q, guessed_d;
    logic                cg_q, cg_d;
    logic                busy_q, busy_d;
    logic                rv_q, rv_d;
    logic                hit_q, hit_d;
    logic                rep_q, rep_d;
    logic                win_q, win_d;
    logic                lose_q, lose_d;

    logic [3:0]          eff_len;
    logic [3:0]          last_idx;
    logic [WORD_LEN-1:0] len_mask;
    logic [7:0]          cur_char;
    logic                rise;
    logic                letter_ok;
    logic [4:0]          k;
    logic                rep;
    logic                any_hit;
    logic [WORD_LEN-1:0] new_rev;
    logic [2:0]          new_wrong;

    // Effective length, active-position mask and current scan character
    always_comb begin
        if (gif.word_len == 4'd0)
            eff_len = 4'd1;
        else if (int'(gif.word_len) > WORD_LEN)
            eff_len = 4'(WORD_LEN);
        else
            eff_len = gif.word_len;
        last_idx = eff_len - 4'd1;
        len_mask = '0;
        for (int i = 0; i < WORD_LEN; i++)
            len_mask[i] = (i < int'(eff_len));
        cur_char  = gif.secret_word[{idx_q, 3'b000} +: 8];
        rise      = gif.check_guess & ~cg_q;
        letter_ok = (gif.guess_letter >= 8'h41) && (gif.guess_letter <= 8'h5A);
        k         = 5'(g_q - 8'h41);
        rep       = guessed_q[k];
        any_hit   = |hit_mask_q;
        new_rev   = revealed_q | hit_mask_q;
        new_wrong = wrong_q;
        if (!any_hit && !rep && (wrong_q != 3'(MAX_WRONG)))
            new_wrong = wrong_q + 3'd1;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        g_d        = g_q;
        hit_mask_d = hit_mask_q;
        revealed_d = revealed_q;
        wrong_d    = wrong_q;
        guessed_d  = guessed_q;
        cg_d       = gif.check_guess;
        busy_d     = busy_q;
        rv_d       = 1'b0;
        hit_d      = 1'b0;
        rep_d      = 1'b0;
        win_d      = win_q;
        lose_d     = lose_q;

        if (gif.init) begin
            // New game: identical to reset, any in-flight guess is dropped.
            state_d    = IDLE;
            idx_d      = '0;
            g_d        = '0;
            hit_mask_d = '0;
            revealed_d = '0;
            wrong_d    = '0;
            guessed_d  = '0;
            cg_d       = 1'b0;
            busy_d     = 1'b0;
            win_d      = 1'b0;
            lose_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Non-letter placeholders are silently ignored.
                    if (rise && letter_ok) begin
                        g_d        = gif.guess_letter;
                        hit_mask_d = '0;
                        idx_d      = '0;
                        busy_d     = 1'b1;
                        state_d    = SCAN;
                    end
                end
                SCAN: begin
                    hit_mask_d[idx_q] = (cur_char == g_q);
                    if (4'(idx_q) == last_idx) begin
                        idx_d   = '0;
                        state_d = UPDATE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                UPDATE: begin
                    revealed_d   = new_rev;
                    wrong_d      = new_wrong;
                    guessed_d[k] = 1'b1;
                    rv_d         = 1'b1;
                    hit_d        = any_hit;
                    rep_d        = rep;
                    busy_d       = 1'b0;
                    if ((new_rev & len_mask) == len_mask) begin
                        win_d   = 1'b1;
                        state_d = OVER;
                    end else if (new_wrong == 3'(MAX_WRONG)) begin
                        lose_d  = 1'b1;
                        state_d = OVER;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: ; // OVER: frozen until a new game
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            g_q        <= '0;
            hit_mask_q <= '0;
            revealed_q <= '0;
            wrong_q    <= '0;
            guessed_q  <= '0;
            cg_q       <= 1'b0;
            busy_q     <= 1'b0;
            rv_q       <= 1'b0;
            hit_q      <= 1'b0;
            rep_q      <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            g_q        <= g_d;
            hit_mask_q <= hit_mask_d;
            revealed_q <= revealed_d;
            wrong_q    <= wrong_d;
            guessed_q  <= guessed_d;
            cg_q       <= cg_d;
            busy_q     <= busy_d;
            rv_q       <= rv_d;
            hit_q      <= hit_d;
            rep_q      <= rep_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
        end
    end

    assign gif.revealed     = revealed_q;
    assign gif.wrong_count  = wrong_q;
    assign gif.guessed_set  = guessed_q;
    assign gif.busy         = busy_q;
    assign gif.result_valid = rv_q;
    assign gif.hit          = hit_q;
    assign gif.repeat_guess = rep_q;
    assign gif.win          = win_q;
    assign gif.lose         = lose_q;
endmodule

// File: tb/tb_hangman_guess_checker.sv
// Directed bench for hangman_guess_checker.
module tb_hangman_guess_checker;
    localparam int WORD_LEN = 8;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_errors;
    int   lat;
    int   nres;
    logic hit_s;
    logic rep_s;

    hangman_guess_checker_if #(.WORD_LEN(WORD_LEN)) gif ();

    hangman_guess_checker #(.WORD_LEN(WORD_LEN), .MAX_WRONG(6)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .gif   (gif)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*WORD_LEN-1:0] mk_word(input string s);
        logic [8*WORD_LEN-1:0] w;
        w = '0;
        for (int i = 0; i < s.len() && i < WORD_LEN; i++)
            w[8*i +: 8] = s[i];
        return w;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic new_game(input string s, input logic [3:0] len);
        gif.secret_word = mk_word(s);
        gif.word_len    = len;
        gif.init        = 1'b1;
        tick();
        gif.init        = 1'b0;
        tick();
    endtask

    // One-cycle check_guess pulse, then watch 20 cycles for results.
    task automatic guess(input logic [7:0] letter);
        gif.guess_letter = letter;
        gif.check_guess  = 1'b1;
        tick();
        gif.check_guess  = 1'b0;
        lat   = -1;
        nres  = 0;
        hit_s = 1'b0;
        rep_s = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (gif.result_valid) begin
                nres++;
                if (lat < 0) lat = n;
                hit_s = gif.hit;
                rep_s = gif.repeat_guess;
            end
        end
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        Reset            = 1'b0;
        gif.init         = 1'b0;
        gif.secret_word  = '0;
        gif.word_len     = 4'd0;
        gif.check_guess  = 1'b0;
        gif.guess_letter = 8'h00;
        tick();
        tick();
        check("rst_revealed", 32'(gif.revealed), 32'h0);
        check("rst_wrong", 32'(gif.wrong_count), 32'h0);
        check("rst_guessed", 32'(gif.guessed_set), 32'h0);
        check("rst_busy", 32'(gif.busy), 32'h0);
        check("rst_rv", 32'(gif.result_valid), 32'h0);
        check("rst_winlose", 32'({gif.win, gif.lose}), 32'h0);
        Reset = 1'b1;
        tick();

        // First hit on "MAZE"
        new_game("MAZE", 4'd4);
        guess("A");
        check("A_lat", 32'(lat), 32'd5);
        check("A_nres", 32'(nres), 32'd1);
        check("A_hit", 32'(hit_s), 32'd1);
        check("A_rep", 32'(rep_s), 32'd0);
        check("A_revealed", 32'(gif.revealed), 32'h02);
        check("A_wrong", 32'(gif.wrong_count), 32'd0);
        check("A_guessed", 32'(gif.guessed_set), 32'h1);

        // Miss, then repeated miss costs nothing
        guess("Q");
        check("Q_hit", 32'(hit_s), 32'd0);
        check("Q_wrong", 32'(gif.wrong_count), 32'd1);
        guess("Q");
        check("Q2_rep", 32'(rep_s), 32'd1);
        check("Q2_nres", 32'(nres), 32'd1);
        check("Q2_wrong", 32'(gif.wrong_count), 32'd1);

        // Complete the word -> win, then further guesses ignored
        guess("M");
        guess("Z");
        check("Z_win_early", 32'(gif.win), 32'd0);
        guess("E");
        check("E_hit", 32'(hit_s), 32'd1);
        check("win_revealed", 32'(gif.revealed), 32'h0F);
        check("win", 32'(gif.win), 32'd1);
        check("win_nolose", 32'(gif.lose), 32'd0);
        guess("B");
        check("over_nres", 32'(nres), 32'd0);
        check("over_guessed", 32'(gif.guessed_set), 32'h2011011);
        check("over_wrong", 32'(gif.wrong_count), 32'd1);

        // Six distinct misses -> lose
        new_game("MAZE", 4'd4);
        check("init_win_clr", 32'(gif.win), 32'd0);
        guess("B"); guess("C"); guess("D"); guess("F"); guess("G");
        check("five_wrong", 32'(gif.wrong_count), 32'd5);
        check("five_nolose", 32'(gif.lose), 32'd0);
        guess("H");
        check("lose_wrong", 32'(gif.wrong_count), 32'd6);
        check("lose", 32'(gif.lose), 32'd1);
        check("lose_nowin", 32'(gif.win), 32'd0);
        guess("M");
        check("lose_M_nres", 32'(nres), 32'd0);
        check("lose_M_rev", 32'(gif.revealed), 32'h0);

        // Level held high for 20 cycles counts once
        new_game("MAZE", 4'd4);
        gif.guess_letter = "E";
        gif.check_guess  = 1'b1;
        nres = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (n == 19) gif.check_guess = 1'b0;
            if (gif.result_valid) nres++;
        end
        check("hold_nres", 32'(nres), 32'd1);
        check("hold_rev", 32'(gif.revealed), 32'h08);

        // Non-letter byte ignored
        guess(8'h01);
        check("ph_nres", 32'(nres), 32'd0);
        check("ph_guessed", 32'(gif.guessed_set), 32'h10);

        // Second rise during SCAN is dropped
        gif.guess_letter = "M";
        gif.check_guess  = 1'b1;
        tick();
        check("scan_busy", 32'(gif.busy), 32'd1);
        gif.check_guess  = 1'b0;
        tick();
        gif.guess_letter = "Z";
        gif.check_guess  = 1'b1;
        tick();
        gif.check_guess  = 1'b0;
        nres = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (gif.result_valid) nres++;
        end
        check("drop_nres", 32'(nres), 32'd1);
        check("drop_rev", 32'(gif.revealed), 32'h09);
        check("drop_guessed", 32'(gif.guessed_set), 32'h1010);

        // Asynchronous reset in the middle of a scan
        gif.guess_letter = "A";
        gif.check_guess  = 1'b1;
        tick();
        gif.check_guess  = 1'b0;
        tick();
        Reset = 1'b0;
        #1;
        check("arst_busy", 32'(gif.busy), 32'd0);
        check("arst_rev", 32'(gif.revealed), 32'h0);
        check("arst_guessed", 32'(gif.guessed_set), 32'h0);
        #2;
        Reset = 1'b1;
        tick();

        // init during a scan aborts the guess
        new_game("MAZE", 4'd4);
        guess("A");
        check("pre_init_rev", 32'(gif.revealed), 32'h02);
        gif.guess_letter = "Z";
        gif.check_guess  = 1'b1;
        tick();
        gif.check_guess  = 1'b0;
        tick();
        gif.init = 1'b1;
        tick();
        gif.init = 1'b0;
        check("init_busy", 32'(gif.busy), 32'd0);
        nres = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (gif.result_valid) nres++;
        end
        check("init_nres", 32'(nres), 32'd0);
        check("init_rev", 32'(gif.revealed), 32'h0);
        check("init_guessed", 32'(gif.guessed_set), 32'h0);

        // word_len 0 behaves as length 1
        new_game("X", 4'd0);
        guess("X");
        check("len0_lat", 32'(lat), 32'd2);
        check("len0_rev", 32'(gif.revealed), 32'h01);
        check("len0_win", 32'(gif.win), 32'd1);

        // word_len above WORD_LEN clamps to WORD_LEN
        new_game("ABCDEFGH", 4'd15);
        guess("H");
        check("clamp_lat", 32'(lat), 32'd9);
        check("clamp_hit", 32'(hit_s), 32'd1);
        check("clamp_rev", 32'(gif.revealed), 32'h80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/hangman_guess_checker.md
Name: hangman_guess_checker

Overview:
- Consumer end of the letter-pickup path: takes the collected-letter byte and the check_guess strobe produced by the maze letter-collection logic.
- Scores each guess against the secret word and maintains the revealed-position mask, wrong-guess count, already-guessed alphabet and win/lose status.
- Sits between the maze letter logic and the word/gallows display logic.
- Scans the word sequentially, one character per clock, to keep the comparator small.

Parameters:
- WORD_LEN, 8, maximum secret word length in characters.
- MAX_WRONG, 6, number of wrong guesses that ends the game (lose).

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- init  input  1  synchronous new-game strobe; clears all game state; takes priority over everything except Reset.
- secret_word  input  8*WORD_LEN  ASCII word; char i at bits [8*i+7:8*i], i=0 leftmost; must be stable while busy.
- word_len  input  4  active length; 0 treated as 1; values >WORD_LEN clamped to WORD_LEN.
- check_guess  input  1  guess strobe (level from a slower clock domain-derived register); acted on at its rising edge only.
- guess_letter  input  8  ASCII letter collected; sampled on the detected rising edge.
- revealed  output  WORD_LEN  bit i=1: char i has been guessed.
- wrong_count  output  3  wrong guesses so far, saturates at MAX_WRONG.
- guessed_set  output  26  bit k=1: letter 'A'+k already guessed.
- busy  output  1  scan in progress.
- result_valid  output  1  one-cycle pulse when a guess has been scored.
- hit  output  1  valid with result_valid: guess matched >=1 position.
- repeat_guess  output  1  valid with result_valid: letter already in guessed_set.
- win  output  1  sticky until init/Reset.
- lose  output  1  sticky until init/Reset.

Behaviour:
- Reset low, at any time including mid-scan: all outputs 0, state IDLE, edge register 0, idx 0.
- init high at a Clk edge produces the same clear as Reset. Any guess in flight is aborted with no result_valid.
- Edge detect: cg_q <= check_guess every cycle; rise = check_guess & ~cg_q. A level held high for many cycles counts as one guess.
- States IDLE, SCAN, UPDATE, OVER.
- IDLE:
  - On rise, latch guess_letter into g and clear hit_mask; busy=1 next cycle; go to SCAN with idx=0.
  - If g is not in 0x41..0x5A (e.g. 0x00/0x01 placeholders), the guess is ignored: stay IDLE, no result_valid.
- SCAN:
  - Each cycle, hit_mask[idx] <= (secret_word char idx == g).
  - idx increments; on idx == eff_len-1, go to UPDATE.
  - Rises during SCAN/UPDATE are dropped, not queued.
- UPDATE (one cycle), with k = g-0x41:
  - repeat_guess = guessed_set[k].
  - revealed |= hit_mask; guessed_set[k] <= 1.
  - If hit_mask==0 and !repeat, wrong_count++ (saturating).
  - result_valid=1 and hit=|hit_mask; busy=0 next cycle.
  - A repeat guess that hits still sets hit=1 but costs nothing.
- Next state after UPDATE:
  - OVER if the new revealed covers all bits < eff_len (win<=1) or the new wrong_count==MAX_WRONG (lose<=1).
  - Otherwise IDLE.
  - win and lose are mutually exclusive: a hit never increments wrong_count.
- OVER: ignore all rises; hold outputs; leave only via init/Reset.
- Latency: rise detected at edge T; result_valid is high in the cycle after edge T+eff_len+1, i.e. eff_len+1 cycles after the capture edge. win/lose/revealed are updated on the same edge that drops result_valid's source (visible the cycle after UPDATE).
- revealed bits >= eff_len stay 0.

Test Plan:
- Word "MAZE", len 4; rise with 'A' -> after 5 cycles result_valid=1, hit=1, revealed=0b0010 (bit1), wrong_count=0, guessed_set bit0=1.
- Same game; guess 'Q' -> hit=0, wrong_count=1; guess 'Q' again -> repeat_guess=1, wrong_count stays 1.
- Guess 'M','Z','E' after 'A' -> the last UPDATE gives revealed=0b1111 and win=1; a further rise with 'B' produces no result_valid and no change.
- Six distinct misses ('B','C','D','F','G','H') -> wrong_count=6, lose=1; a subsequent 'M' is ignored.
- Hold check_guess high for 20 cycles with 'E' -> exactly one result_valid. Rise with 0x01 -> nothing happens. Second rise during SCAN -> dropped.
- Reset low mid-SCAN -> all outputs 0 immediately; init during SCAN -> clear with no result_valid. word_len=0 with "X..." and guess 'X' -> latency 2, win=1.
